vic_regbank: RTL

Parametrised, double-buffered configuration register bank for the VIC core: the successor to the fixed 32×4 register file. Host writes land in a shadow bank, and a commit request copies the shadow bank into the active bank at the next frame-sync strobe, so downstream logic never sees a half-updated configuration. It adds a lock bit, out-of-range error reporting and a fixed 1-cycle read handshake, and drives the flattened active-configuration bus and global enable into the VIC datapath.

---
 rtl/vic_regbank_pkg.sv | 19 +
 rtl/vic_regbank_commit_fsm.sv | 46 ++++
 rtl/vic_regbank.sv | 115 +++++++++++
 3 files changed

// File: rtl/vic_regbank_pkg.sv
// Shared definitions for the VIC configuration register bank: default
// geometry, control-register bit positions and the commit FSM encoding.
package vic_regbank_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_CTRL_IDX = 31;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } commit_state_e;

endpackage

// File: rtl/vic_regbank_commit_fsm.sv
// Commit sequencer: arms on a commit request, waits for the frame-sync
// strobe, then issues a single-cycle copy enable for the active bank.
module vic_commit_fsm
    import vic_regbank_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_commit,
    input  logic i_vsync,
    output logic copy_en,
    output logic pending
);

    commit_state_e state;
    commit_state_e state_next;

    // State register; reset aborts any commit in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and Moore outputs; vsync in IDLE is ignored, commits in ARMED are absorbed.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_next = state;
        copy_en    = 1'b0;
        pending    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_commit) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                pending = 1'b1;
                if (i_vsync) state_next = ST_COPY;
            end
            ST_COPY: begin
                copy_en    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/vic_regbank.sv
// Double-buffered VIC configuration bank: host writes land in the shadow
// bank and are copied to the active bank at a frame boundary after a commit.
// The control register is single-buffered so enable/lock act immediately.
module vic_regbank
    import vic_regbank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CTRL_IDX = DEF_CTRL_IDX
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          i_VIC_regaddr,
    input  logic [DATA_W-1:0]          i_VIC_data,
    input  logic                       i_VIC_we,
    input  logic                       i_VIC_re,
    input  logic                       i_rbank,
    input  logic                       i_commit,
    input  logic                       i_vsync,
    output logic [DATA_W-1:0]          o_VIC_data,
    output logic                       o_rvalid,
    output logic                       o_err,
    output logic                       o_commit_pending,
    output logic                       o_enable,
    output logic [NUM_REGS*DATA_W-1:0] o_buffer
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]  NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] CTRL_SEL   = IDX_W'(CTRL_IDX);

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              is_ctrl;
    logic              locked;
    logic              wr_ok;
    logic              rd_req;
    logic              err_next;
    logic [DATA_W-1:0] rd_word;
    logic              copy_en;

    assign idx      = i_VIC_regaddr[IDX_W-1:0];
    assign in_range = {1'b0, i_VIC_regaddr} < NUM_REGS_A;
    assign is_ctrl  = (idx == CTRL_SEL);
    assign locked   = active[CTRL_IDX][CTRL_LOCK_BIT];
    assign rd_req   = i_VIC_re && !i_VIC_we;
    // The control register stays writable while locked so the lock can be released.
    assign wr_ok    = i_VIC_we && in_range && (is_ctrl || !locked);

    vic_commit_fsm u_commit_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_commit (i_commit),
        .i_vsync  (i_vsync),
        .copy_en  (copy_en),
        .pending  (o_commit_pending)
    );

    // Access decode: error classification and the selected read word.
    always_comb begin
        err_next = 1'b0;
        rd_word  = '0;
        if (i_VIC_we) err_next = !in_range || (!is_ctrl && locked);
        else if (i_VIC_re) err_next = !in_range;
        if (in_range) rd_word = i_rbank ? active[idx] : shadow[idx];
    end

    // Shadow bank: accepted host writes land here (control included).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the banks are cleared on reset because o_buffer must read 0 out of reset.
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (wr_ok) begin
            shadow[idx] <= i_VIC_data;
        end
    end

    // Active bank: bulk copy from shadow on commit, control written directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) active[i] <= '0;
        end else begin
            if (copy_en) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (i != CTRL_IDX) active[i] <= shadow[i];
                end
            end
            if (wr_ok && is_ctrl) active[CTRL_IDX] <= i_VIC_data;
        end
    end

    // Registered read port: data holds between reads, valid/err are pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_VIC_data <= '0;
            o_rvalid   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_rvalid <= rd_req;
            o_err    <= err_next;
            if (rd_req) o_VIC_data <= rd_word;
        end
    end

    assign o_enable = active[CTRL_IDX][CTRL_EN_BIT];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_buffer[DATA_W*g +: DATA_W] = active[g];
    end

endmodule
